complex_fix_div: RTL and testbench

COMPLEX_FIX_DIV -- requirements
Module: complex_fix_div

---
 rtl/complex_fix_div_pkg.sv | 29 ++
 rtl/complex_fix_div_if.sv | 29 ++
 rtl/complex_fix_div_fix_seq_udiv.sv | 92 +++++++++
 rtl/complex_fix_div.sv | 164 ++++++++++++++++
 tb/tb_complex_fix_div.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/complex_fix_div_pkg.sv
// complex_div_pkg: shared types and constants for the complex fixed-point divider.
//   state_t    - control FSM states
//   REAL/IMAG  - component indices into the x, y and out arrays
//   den_bits() - width of the unsigned denominator c^2+d^2
//   num_bits() - width of the signed numerators ac+bd and bc-ad
package complex_div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int REAL = 32'sd0;
  localparam int IMAG = 32'sd1;

  // c^2+d^2 is non-negative and at most 2^(2*in_bits-1), so 2*in_bits unsigned bits hold it.
  function automatic int den_bits(input int in_bits);
    return 32'sd2 * in_bits;
  endfunction

  // Signed sums of two full-precision products.
  function automatic int num_bits(input int in_bits);
    return 32'sd2 * in_bits + 32'sd1;
  endfunction

endpackage

// File: rtl/complex_fix_div_if.sv
// complex_fix_div_if: operand / quotient handshake bundle of the complex divider.
//   in_valid, in_ready, x[0:1], y[0:1]        - operand channel (index 0 real, 1 imag)
//   out_valid, out_ready, out[0:1]            - quotient channel
//   div_by_zero, overflow                     - status, qualified by out_valid
//   master: the operand producer / quotient consumer; slave: the divider.
interface complex_fix_div_if #(
  parameter int IN_BITS  = 37,
  parameter int OUT_BITS = 38
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [IN_BITS-1:0]  x [0:1];
  logic signed [IN_BITS-1:0]  y [0:1];
  logic                       out_valid;
  logic                       out_ready;
  logic signed [OUT_BITS-1:0] out [0:1];
  logic                       div_by_zero;
  logic                       overflow;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, out, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, out, div_by_zero, overflow
  );
endinterface

// File: rtl/complex_fix_div_fix_seq_udiv.sv
// fix_seq_udiv: sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
// Computes floor((dividend << SHIFT) / divisor) as a QW-bit quotient; ovf flags a quotient
// that would need more than QW bits (its bits are then meaningless).
//   clk, reset          - clock, synchronous active-high reset
//   start               - load operands (one-cycle pulse while idle)
//   dividend, divisor   - unsigned operands, divisor must be non-zero
//   busy                - iteration in progress
//   done                - high during the cycle whose edge produces the last quotient bit
//   quotient, ovf       - result, valid once busy has dropped
module fix_seq_udiv #(
  parameter int NW    = 75,
  parameter int DW    = 74,
  parameter int QW    = 38,
  parameter int SHIFT = 35
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient,
  output logic          ovf
);
  localparam int GAP  = QW - SHIFT;
  localparam int CW   = NW + DW + GAP;
  localparam int CNTW = $clog2(QW + 1);

  logic [DW-1:0]   rem_r;
  logic [DW-1:0]   dsr_r;
  logic [QW-1:0]   sh_r;
  logic [QW-1:0]   q_r;
  logic [CNTW-1:0] cnt_r;
  logic            busy_r;
  logic            ovf_r;
  logic            ovf_s;
  logic [DW:0]     trial_s;
  logic            bit_s;
  logic [DW-1:0]   rem_n_s;

  // The quotient fits in QW bits exactly when dividend < divisor << GAP.
  always_comb begin
    ovf_s = (CW'(dividend) >= (CW'(divisor) << GAP));
  end

  // One restoring step: bring in the next dividend bit, subtract if the divisor fits.
  always_comb begin
    trial_s = {rem_r, sh_r[QW-1]};
    if (trial_s >= {1'b0, dsr_r}) begin
      bit_s   = 1'b1;
      rem_n_s = DW'(trial_s - {1'b0, dsr_r});
    end else begin
      bit_s   = 1'b0;
      rem_n_s = DW'(trial_s);
    end
  end

  // Operand load and per-cycle iteration state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      cnt_r  <= {CNTW{1'b0}};
      rem_r  <= {DW{1'b0}};
      dsr_r  <= {DW{1'b0}};
      sh_r   <= {QW{1'b0}};
      q_r    <= {QW{1'b0}};
      ovf_r  <= 1'b0;
    end else if (start) begin
      // Upper dividend bits seed the remainder; the rest (plus SHIFT zeros) are shifted in.
      busy_r <= 1'b1;
      cnt_r  <= CNTW'(QW);
      rem_r  <= DW'(dividend >> GAP);
      dsr_r  <= divisor;
      sh_r   <= QW'(dividend << SHIFT);
      q_r    <= {QW{1'b0}};
      ovf_r  <= ovf_s;
    end else if (busy_r) begin
      rem_r  <= rem_n_s;
      sh_r   <= {sh_r[QW-2:0], 1'b0};
      q_r    <= {q_r[QW-2:0], bit_s};
      cnt_r  <= cnt_r - CNTW'(1);
      busy_r <= (cnt_r != CNTW'(1));
    end
  end

  assign busy     = busy_r;
  assign done     = busy_r && (cnt_r == CNTW'(1));
  assign quotient = q_r;
  assign ovf      = ovf_r;

endmodule

// File: rtl/complex_fix_div.sv
// complex_fix_div: fixed-point complex division out = x / y, truncated toward zero,
// symmetric saturation to +/-(2^(OUT_BITS-1)-1).
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset, aborts any transaction
//   bus    - complex_fix_div_if slave: operand and quotient handshakes, div_by_zero, overflow
// Flow: IDLE latches operands, MUL forms full-precision numerators/denominator,
// DIV runs two parallel restoring dividers for OUT_BITS cycles, FIX applies sign and
// saturation, DONE holds the result until out_ready.
module complex_fix_div
  import complex_div_pkg::*;
#(
  parameter int IN_BITS   = 37,
  parameter int OUT_BITS  = 38,
  parameter int FRAC_BITS = 35
) (
  input logic            clk,
  input logic            reset,
  complex_fix_div_if.slave bus
);
  localparam int NW = num_bits(IN_BITS);
  localparam int DW = den_bits(IN_BITS);
  localparam logic [OUT_BITS-1:0] MAX_MAG = {1'b0, {(OUT_BITS-1){1'b1}}};

  state_t                     state_r;
  state_t                     state_n;
  logic signed [IN_BITS-1:0]  x_r [0:1];
  logic signed [IN_BITS-1:0]  y_r [0:1];
  logic [1:0]                 neg_r;
  logic signed [OUT_BITS-1:0] out_r [0:1];
  logic                       dbz_r;
  logic                       ovf_r;
  logic                       out_valid_r;
  logic                       in_ready_r;

  logic signed [NW-1:0]       a_s, b_s, c_s, d_s;
  logic signed [NW-1:0]       num_re_s, num_im_s, den_full_s;
  logic [NW-1:0]              mag_re_s, mag_im_s;
  logic [DW-1:0]              den_s;
  logic                       start_s;
  logic                       busy_re_s, busy_im_s, done_re_s, done_im_s;
  logic                       qovf_re_s, qovf_im_s;
  logic [OUT_BITS-1:0]        q_re_s, q_im_s;
  logic [1:0]                 sat_s;
  logic [OUT_BITS-1:0]        mag_out_s [0:1];
  logic signed [OUT_BITS-1:0] res_s [0:1];

  // Full-precision numerators and denominator from the latched operands.
  always_comb begin
    a_s        = NW'(x_r[REAL]);
    b_s        = NW'(x_r[IMAG]);
    c_s        = NW'(y_r[REAL]);
    d_s        = NW'(y_r[IMAG]);
    num_re_s   = a_s * c_s + b_s * d_s;
    num_im_s   = b_s * c_s - a_s * d_s;
    den_full_s = c_s * c_s + d_s * d_s;
    den_s      = den_full_s[DW-1:0];
    mag_re_s   = num_re_s[NW-1] ? NW'(-num_re_s) : NW'(num_re_s);
    mag_im_s   = num_im_s[NW-1] ? NW'(-num_im_s) : NW'(num_im_s);
  end

  fix_seq_udiv #(.NW(NW), .DW(DW), .QW(OUT_BITS), .SHIFT(FRAC_BITS)) u_div_re (
    .clk(clk), .reset(reset), .start(start_s), .dividend(mag_re_s), .divisor(den_s),
    .busy(busy_re_s), .done(done_re_s), .quotient(q_re_s), .ovf(qovf_re_s)
  );

  fix_seq_udiv #(.NW(NW), .DW(DW), .QW(OUT_BITS), .SHIFT(FRAC_BITS)) u_div_im (
    .clk(clk), .reset(reset), .start(start_s), .dividend(mag_im_s), .divisor(den_s),
    .busy(busy_im_s), .done(done_im_s), .quotient(q_im_s), .ovf(qovf_im_s)
  );

  // Saturate magnitudes, then restore the numerator sign (truncation toward zero).
  always_comb begin
    sat_s[REAL]     = qovf_re_s || (q_re_s > MAX_MAG);
    sat_s[IMAG]     = qovf_im_s || (q_im_s > MAX_MAG);
    mag_out_s[REAL] = sat_s[REAL] ? MAX_MAG : q_re_s;
    mag_out_s[IMAG] = sat_s[IMAG] ? MAX_MAG : q_im_s;
    res_s[REAL]     = neg_r[REAL] ? -mag_out_s[REAL] : mag_out_s[REAL];
    res_s[IMAG]     = neg_r[IMAG] ? -mag_out_s[IMAG] : mag_out_s[IMAG];
  end

  // Next-state and divider start.
  always_comb begin
    state_n = state_r;
    start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_n = MUL;
        else              state_n = IDLE;
      end
      MUL: begin
        if (den_s == {DW{1'b0}}) begin
          state_n = DONE;
        end else begin
          state_n = DIV;
          start_s = 1'b1;
        end
      end
      DIV: begin
        // Dividers lost without finishing can only follow a fault; fall back to IDLE.
        if (done_re_s && done_im_s)      state_n = FIX;
        else if (busy_re_s && busy_im_s) state_n = DIV;
        else                             state_n = IDLE;
      end
      FIX:  state_n = DONE;
      DONE: begin
        if (out_valid_r && bus.out_ready) state_n = IDLE;
        else                              state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, handshake flags and operand/result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_r[REAL] <= {OUT_BITS{1'b0}};
      out_r[IMAG] <= {OUT_BITS{1'b0}};
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      neg_r       <= 2'b00;
      x_r[REAL]   <= {IN_BITS{1'b0}};
      x_r[IMAG]   <= {IN_BITS{1'b0}};
      y_r[REAL]   <= {IN_BITS{1'b0}};
      y_r[IMAG]   <= {IN_BITS{1'b0}};
    end else begin
      state_r    <= state_n;
      in_ready_r <= (state_n == IDLE);
      // out_valid trails DONE entry by one edge so the result registers are already settled.
      out_valid_r <= (state_r == DONE) && !(out_valid_r && bus.out_ready);
      if ((state_r == IDLE) && bus.in_valid) begin
        x_r[REAL] <= bus.x[REAL];
        x_r[IMAG] <= bus.x[IMAG];
        y_r[REAL] <= bus.y[REAL];
        y_r[IMAG] <= bus.y[IMAG];
      end
      if (state_r == MUL) begin
        neg_r <= {num_im_s[NW-1], num_re_s[NW-1]};
        if (den_s == {DW{1'b0}}) begin
          out_r[REAL] <= {OUT_BITS{1'b0}};
          out_r[IMAG] <= {OUT_BITS{1'b0}};
          dbz_r       <= 1'b1;
          ovf_r       <= 1'b0;
        end
      end
      if (state_r == FIX) begin
        out_r[REAL] <= res_s[REAL];
        out_r[IMAG] <= res_s[IMAG];
        dbz_r       <= 1'b0;
        ovf_r       <= sat_s[REAL] | sat_s[IMAG];
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out[REAL]   = out_r[REAL];
  assign bus.out[IMAG]   = out_r[IMAG];
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_complex_fix_div.sv
// tb_complex_fix_div: table-driven self-checking bench for complex_fix_div with a
// scoreboard queue, plus hand-written hold, divide-by-zero and reset-abort sequences.
module tb_complex_fix_div;
  localparam int IB = 37;
  localparam int OB = 38;
  localparam int FB = 35;

  typedef struct {
    logic signed [IB-1:0] xr, xi, yr, yi;
    logic signed [OB-1:0] ore, oim;
    logic                 ovf, dbz;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  complex_fix_div_if #(.IN_BITS(IB), .OUT_BITS(OB)) bus ();
  complex_fix_div #(.IN_BITS(IB), .OUT_BITS(OB), .FRAC_BITS(FB)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  vec_t sbq[$];
  vec_t tbl[12];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    $display("FAIL %s: got no response within bound, expected one", nm);
  endtask

  function automatic vec_t mk(input logic signed [IB-1:0] xr, xi, yr, yi,
                              input logic signed [OB-1:0] ore, oim, input logic ovf, dbz);
    vec_t v;
    v.xr = xr; v.xi = xi; v.yr = yr; v.yi = yi;
    v.ore = ore; v.oim = oim; v.ovf = ovf; v.dbz = dbz;
    return v;
  endfunction

  // Reference: exact wide arithmetic, floor of magnitude, symmetric clamp.
  function automatic vec_t model(input logic signed [IB-1:0] xr, xi, yr, yi);
    vec_t v;
    logic signed [159:0] a, b, c, d, nre, nim, den;
    logic [159:0] mre, mim, qre, qim, lim;
    a = 160'(xr); b = 160'(xi); c = 160'(yr); d = 160'(yi);
    nre = a * c + b * d;
    nim = b * c - a * d;
    den = c * c + d * d;
    lim = (160'(1) << (OB - 1)) - 160'(1);
    v = mk(xr, xi, yr, yi, '0, '0, 1'b0, 1'b0);
    if (den == 0) begin
      v.dbz = 1'b1;
    end else begin
      mre = (nre < 0) ? 160'(-nre) : 160'(nre);
      mim = (nim < 0) ? 160'(-nim) : 160'(nim);
      qre = (mre << FB) / 160'(den);
      qim = (mim << FB) / 160'(den);
      if (qre > lim) begin qre = lim; v.ovf = 1'b1; end
      if (qim > lim) begin qim = lim; v.ovf = 1'b1; end
      v.ore = (nre < 0) ? -OB'(qre) : OB'(qre);
      v.oim = (nim < 0) ? -OB'(qim) : OB'(qim);
    end
    return v;
  endfunction

  // Drive one transaction, check latency and result, optionally stall the consumer.
  task automatic run_txn(input vec_t v, input int hold, input string nm);
    int lat;
    int w;
    vec_t e;
    @(negedge clk);
    bus.x[0] = v.xr; bus.x[1] = v.xi; bus.y[0] = v.yr; bus.y[1] = v.yi;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 100) begin @(negedge clk); w++; end
    if (!bus.in_ready) begin
      tmo({nm, "_in_ready"});
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sbq.push_back(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    chk({nm, "_busy_in_ready"}, bus.in_ready, 1'b0);
    while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
    e = sbq.pop_front();
    if (!bus.out_valid) begin
      tmo({nm, "_out_valid"});
      return;
    end
    chk({nm, "_latency"}, lat, e.dbz ? 2 : OB + 3);
    chk({nm, "_re"}, bus.out[0], e.ore);
    chk({nm, "_im"}, bus.out[1], e.oim);
    chk({nm, "_ovf"}, bus.overflow, e.ovf);
    chk({nm, "_dbz"}, bus.div_by_zero, e.dbz);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, bus.out_valid, 1'b1);
      chk({nm, "_hold_in_ready"}, bus.in_ready, 1'b0);
      chk({nm, "_hold_re"}, bus.out[0], e.ore);
      chk({nm, "_hold_im"}, bus.out[1], e.oim);
      chk({nm, "_hold_flags"}, {bus.overflow, bus.div_by_zero}, {e.ovf, e.dbz});
      bus.in_valid = (h % 2 == 0);
      bus.x[0] = IB'($urandom());
      bus.y[0] = IB'($urandom());
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, "_post_valid"}, bus.out_valid, 1'b0);
    chk({nm, "_post_in_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    logic signed [IB-1:0] one, half, qtr, tq, op5, mn, lsb;
    logic [63:0] r;
    one = 37'sd34359738368; half = 37'sd17179869184; qtr = 37'sd8589934592;
    tq = 37'sd25769803776;  op5 = 37'sd51539607552;  lsb = 37'sd1;
    mn = {1'b1, {(IB-1){1'b0}}};

    tbl[0] = mk(one, '0, one, '0, 38'sd34359738368, '0, 1'b0, 1'b0);
    tbl[1] = mk(one, one, one, -one, '0, 38'sd34359738368, 1'b0, 1'b0);
    tbl[2] = mk(half, '0, '0, one, '0, -38'sd17179869184, 1'b0, 1'b0);
    tbl[3] = mk(op5, -qtr, '0, '0, '0, '0, 1'b0, 1'b1);
    tbl[4] = mk(op5, '0, lsb, '0, 38'sd137438953471, '0, 1'b1, 1'b0);
    tbl[5] = mk(-op5, '0, lsb, '0, -38'sd137438953471, '0, 1'b1, 1'b0);
    tbl[6] = mk(tq, one, qtr, half, 38'sd75591424409, -38'sd13743895347, 1'b0, 1'b0);
    for (int i = 7; i < 10; i++) begin
      r = {$urandom(), $urandom()};
      tbl[i] = model(r[36:0], r[63:27], IB'($urandom()), (i == 9) ? IB'(r[5:0]) : IB'($urandom()));
    end
    tbl[10] = model(IB'($urandom()), IB'($urandom()), '0, IB'($signed(r[40:30])));
    tbl[11] = model(mn, mn, mn, '0);

    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    bus.x[0] = '0; bus.x[1] = '0; bus.y[0] = '0; bus.y[1] = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_re", bus.out[0], '0);
    chk("rst_out_im", bus.out[1], '0);
    chk("rst_dbz", bus.div_by_zero, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_txn(tbl[i], 0, $sformatf("vec%0d", i));

    run_txn(tbl[6], 10, "hold");
    run_txn(tbl[2], 0, "after_hold");
    run_txn(tbl[3], 3, "dbz_hold");

    // Abort during the fifth DIV cycle, then run a fresh transaction.
    @(negedge clk);
    bus.x[0] = tbl[4].xr; bus.x[1] = tbl[4].xi; bus.y[0] = tbl[4].yr; bus.y[1] = tbl[4].yi;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b0;
    chk("abort_out_valid", bus.out_valid, 1'b0);
    chk("abort_in_ready", bus.in_ready, 1'b1);
    chk("abort_out_re", bus.out[0], '0);
    run_txn(tbl[6], 0, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
